cmp_search_ctrl: RTL
====================

Name: cmp_search_ctrl

Overview:
- Initiator side of the magnitude-compare interface. Our existing comparator blocks answer one less/equal/greater query.
- This block asks the queries: it drives successive guesses to an external comparator/responder and consumes its less/equal/greater verdicts.
- It binary-searches an unknown target in 0..2^WIDTH-1 and reports the located value, the step count, and the success or failure status.
- Used by the guess-number and threshold-find lab designs.

Parameters:
- WIDTH, 8, bit width of the guess and result; search range is 0..2^WIDTH-1.
- STEP_W, 4, width of the step counter; must satisfy 2^STEP_W > WIDTH+1.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- guess  out  WIDTH  current query value, driven to the comparator's a input (target on b).
- guess_valid  out  1  guess is stable and awaiting a verdict.
- cmp_valid  in  1  responder's verdict is valid this cycle.
- less  in  1  guess < target.
- equal  in  1  guess == target.
- greater  in  1  guess > target.
- busy  out  1  search in progress (CMP or UPD).
- done  out  1  one-cycle pulse at search end.
- found  out  1  last search hit equal; held until next start.
- err  out  1  last search aborted on an illegal verdict; held until next start.
- result  out  WIDTH  matched value when found=1, else last guess; held until next start.
- steps  out  STEP_W  number of verdicts consumed by the last or current search.

Behaviour:
- Reset (sys_rst=1 at an edge): state=IDLE; guess, guess_valid, busy, done, found, err, result, steps all 0; lo=0, hi=2^WIDTH-1. Reset mid-search abandons it immediately; no done pulse.
- States: IDLE, CMP, UPD, FIN.
- IDLE, start=1:
  - Load lo=0, hi=2^WIDTH-1, steps=0; clear found, err, result.
  - guess = (2^WIDTH-1)>>1; go to CMP.
  - guess_valid=1 and busy=1 from the next cycle.
- start while not IDLE is ignored.
- CMP: guess_valid=1, guess held constant. The block waits indefinitely for cmp_valid and does not time out. It samples the verdict only when cmp_valid=1 in CMP; at that edge steps increments and:
  - Exactly equal: found=1, result=guess; go to FIN.
  - Exactly less:
    - If guess==hi: found=0, result=guess; go to FIN.
    - Otherwise lo=guess+1; go to UPD.
  - Exactly greater:
    - If guess==lo: found=0, result=guess; go to FIN.
    - Otherwise hi=guess-1; go to UPD.
  - Zero or more than one of less/equal/greater asserted: err=1, found=0, result=guess; go to FIN.
- The guess==lo / guess==hi checks are what prevent lo/hi wrap-around; no WIDTH+1 arithmetic is required.
- UPD (1 cycle): guess_valid=0, guess=lo+((hi-lo)>>1); computed in WIDTH bits, no overflow. Then go to CMP.
- FIN (1 cycle): done=1, busy=0, guess_valid=0; then go to IDLE.
- Timing: the minimum cost per comparison is 2 cycles (CMP plus UPD) when cmp_valid is returned in the first CMP cycle.
- Step bound: a consistent responder ends in at most WIDTH+1 steps.
- cmp_valid outside CMP is ignored.

Decomposition:
- Shared package (cmp_pkg):
  - State encoding constants: IDLE, CMP, UPD, FIN.
  - Verdict one-hot codes {less, equal, greater}: 3'b100, 3'b010, 3'b001.
  - Legal-verdict check function.
- No sub-module; the midpoint is a single expression.
- The bench responder instantiates our existing WIDTH-matched comparator with target on b.

Test Plan:
- Target 100, responder answers same cycle → guesses 127,63,95,111,103,99,101,100; done pulse with found=1, result=100, steps=8, err=0.
- Target 255 → final guesses 253,254,255; found=1, result=255, steps=9. Target 0 → guesses 127,63,…,1,0; found=1, result=0, steps=8.
- Lying responder always "less" → guess climbs to 255, then less at guess==hi; found=0, result=255, steps=9, no wrap to 0.
- Verdict 3'b000 or 3'b110 with cmp_valid at first guess → err=1, found=0, result=127, steps=1, done pulse.
- Responder delays cmp_valid by 5 cycles with verdicts toggling while invalid → guess stable and guess_valid=1 throughout, verdicts ignored; start pulsed mid-search is ignored.
- sys_rst asserted in CMP after step 3 → next cycle all outputs 0, no done; new start restarts from guess 127.

Source files
------------

// File: rtl/cmp_search_ctrl_pkg.sv
// Shared types and verdict helpers for the magnitude-compare search initiator.
package cmp_search_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_UPD  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Verdict bundle ordering is {less, equal, greater}
    localparam logic [2:0] V_LESS    = 3'b100;
    localparam logic [2:0] V_EQUAL   = 3'b010;
    localparam logic [2:0] V_GREATER = 3'b001;

    function automatic logic verdict_legal(input logic [2:0] v);
        return (v == V_LESS) || (v == V_EQUAL) || (v == V_GREATER);
    endfunction

endpackage

// File: rtl/cmp_search_ctrl_if.sv
// Query/verdict link between the search initiator and a comparator responder.
interface cmp_search_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic             cmp_valid;
    logic             less;
    logic             equal;
    logic             greater;

    modport master (
        output guess, guess_valid,
        input  cmp_valid, less, equal, greater
    );

    modport slave (
        input  guess, guess_valid,
        output cmp_valid, less, equal, greater
    );
endinterface

// File: rtl/cmp_search_ctrl.sv
// Binary search for an unknown target by issuing guesses to an external comparator.
// state | meaning: IDLE wait start | CMP guess out, await verdict | UPD form next midpoint | FIN done pulse
module cmp_search_ctrl
    import cmp_search_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    cmp_search_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              err,
    output logic [WIDTH-1:0]  result,
    output logic [STEP_W-1:0] steps
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d, guess_q, guess_d, result_q, result_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              found_q, found_d, err_q, err_d;
    logic [2:0]        verdict;

    assign verdict = {bus.less, bus.equal, bus.greater};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= MAX_VAL;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        steps_d  = steps_q;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = MAX_VAL;
                    steps_d  = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    guess_d  = MAX_VAL >> 1;
                    state_d  = S_CMP;
                end
            end
            S_CMP: begin
                if (bus.cmp_valid) begin
                    steps_d = steps_q + 1'b1;
                    if (!verdict_legal(verdict)) begin
                        err_d    = 1'b1;
                        found_d  = 1'b0;
                        result_d = guess_q;
                        state_d  = S_FIN;
                    end else if (verdict == V_EQUAL) begin
                        found_d  = 1'b1;
                        result_d = guess_q;
                        state_d  = S_FIN;
                    end else if (verdict == V_LESS) begin
                        // Bound checks stop lo/hi from wrapping past the range ends
                        if (guess_q == hi_q) begin
                            found_d  = 1'b0;
                            result_d = guess_q;
                            state_d  = S_FIN;
                        end else begin
                            lo_d    = guess_q + 1'b1;
                            state_d = S_UPD;
                        end
                    end else begin
                        if (guess_q == lo_q) begin
                            found_d  = 1'b0;
                            result_d = guess_q;
                            state_d  = S_FIN;
                        end else begin
                            hi_d    = guess_q - 1'b1;
                            state_d = S_UPD;
                        end
                    end
                end
            end
            S_UPD: begin
                guess_d = lo_q + ((hi_q - lo_q) >> 1);
                state_d = S_CMP;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.guess       = guess_q;
    assign bus.guess_valid = (state_q == S_CMP);
    assign busy            = (state_q == S_CMP) || (state_q == S_UPD);
    assign done            = (state_q == S_FIN);
    assign found           = found_q;
    assign err             = err_q;
    assign result          = result_q;
    assign steps           = steps_q;

endmodule
